// File: rtl/wave_tbl_pkg.sv
// wave_tbl_pkg: shared types and default widths for the wave table
// player slice (sequencer state, table/sample/hold widths).
package wave_tbl_pkg;

  localparam int WT_A      = 4;
  localparam int WT_D      = 16;
  localparam int WT_HOLD_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND
  } state_t;

endpackage

// File: rtl/wave_tbl_addr_gen.sv
// wave_tbl_addr_gen: table pointer with load/advance/wrap plus the
// lo/hi/loop range registers.
// Ports: clk, rst; load latches range and sets ptr=addr_lo;
// step advances ptr (wrapping to lo_q at hi_q when looping);
// ptr, at_hi (ptr==hi_q) and loop_q are returned to the sequencer.
module wave_tbl_addr_gen
  import wave_tbl_pkg::*;
#(
  parameter int A = WT_A
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [A-1:0] addr_lo,
  input  logic [A-1:0] addr_hi,
  input  logic         loop,
  output logic [A-1:0] ptr,
  output logic         at_hi,
  output logic         loop_q
);

  logic [A-1:0] lo_q;
  logic [A-1:0] hi_q;

  assign at_hi = (ptr == hi_q);

  // ptr+1 wraps modulo 2^A, so lo>hi ranges pass through 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q   <= '0;
      hi_q   <= '0;
      loop_q <= 1'b0;
      ptr    <= '0;
    end else if (load) begin
      lo_q   <= addr_lo;
      hi_q   <= addr_hi;
      loop_q <= loop;
      ptr    <= addr_lo;
    end else if (step) begin
      if (at_hi && loop_q) ptr <= lo_q;
      else                 ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/wave_tbl_player.sv
// wave_tbl_player: walks a WaveTblSig address range, captures sigA/sigB
// and streams samples over valid/ready with optional loop and repeat.
// Ports: clk, rst (sync, active-high); start/stop/loop/addr_lo/addr_hi/
// hold config; tbl_addr/tbl_sigA/tbl_sigB table side; out_valid/
// out_ready/out_a/out_b/out_last stream; busy and done status.
module wave_tbl_player
  import wave_tbl_pkg::*;
#(
  parameter int A      = WT_A,
  parameter int D      = WT_D,
  parameter int HOLD_W = WT_HOLD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [A-1:0]      addr_lo,
  input  logic [A-1:0]      addr_hi,
  input  logic [HOLD_W-1:0] hold,
  output logic [A-1:0]      tbl_addr,
  input  logic [D-1:0]      tbl_sigA,
  input  logic [D-1:0]      tbl_sigB,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [D-1:0]      out_a,
  output logic [D-1:0]      out_b,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  state_t            state_q;
  state_t            state_d;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hcnt;
  logic [HOLD_W-1:0] hcnt_inc;
  logic              stop_pend;
  logic [A-1:0]      ptr;
  logic              at_hi;
  logic              loop_q;

  logic xfer;
  logic more;
  logic end_nat;
  logic last_ok;
  logic load;
  logic fetch;
  logic sx;
  logic rep;
  logic fin;
  logic step;

  wave_tbl_addr_gen #(
    .A(A)
  ) u_addr (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .addr_lo(addr_lo),
    .addr_hi(addr_hi),
    .loop   (loop),
    .ptr    (ptr),
    .at_hi  (at_hi),
    .loop_q (loop_q)
  );

  assign tbl_addr = ptr;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        state_d = SEND;
      end
      SEND: begin
        unique case (1'b1)
          fin:     state_d = IDLE;
          step:    state_d = FETCH;
          default: state_d = SEND;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  // Control decode: a SEND transfer either repeats the sample,
  // steps to the next entry, or finishes the sequence.
  always_comb begin
    xfer     = out_valid & out_ready;
    more     = (hcnt < hold_q);
    hcnt_inc = hcnt + 1'b1;
    end_nat  = !more & at_hi & !loop_q;
    // A pending or arriving stop suppresses out_last on new samples.
    last_ok  = at_hi & !loop_q & !stop_pend & !stop;
    load     = (state_q == IDLE) & start;
    fetch    = (state_q == FETCH);
    sx       = (state_q == SEND) & xfer;
    rep      = sx & !stop_pend & more;
    fin      = sx & (stop_pend | end_nat);
    step     = sx & !stop_pend & !more & !end_nat;
    busy     = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= '0;
      hcnt      <= '0;
      stop_pend <= 1'b0;
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= fin;
      if (load) begin
        hold_q    <= hold;
        hcnt      <= '0;
        stop_pend <= 1'b0;
      end else if (busy && stop) begin
        stop_pend <= 1'b1;
      end
      if (fetch) begin
        out_a     <= tbl_sigA;
        out_b     <= tbl_sigB;
        out_valid <= 1'b1;
        out_last  <= last_ok & (hold_q == '0);
      end
      if (rep) begin
        hcnt     <= hcnt_inc;
        out_last <= last_ok & (hcnt_inc == hold_q);
      end
      // Dropping valid here is the FETCH bubble between entries.
      if (step || fin) begin
        hcnt      <= '0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wave_tbl_player.sv
// tb_wave_tbl_player: table vectors, hand sequences and random runs
// of wave_tbl_player against a list-building reference model.
module tb_wave_tbl_player;

  localparam int A  = 4;
  localparam int D  = 16;
  localparam int HW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic          loop;
  logic [A-1:0]  addr_lo;
  logic [A-1:0]  addr_hi;
  logic [HW-1:0] hold;
  logic [A-1:0]  tbl_addr;
  logic [D-1:0]  tbl_sigA;
  logic [D-1:0]  tbl_sigB;
  logic          out_valid;
  logic          out_ready;
  logic [D-1:0]  out_a;
  logic [D-1:0]  out_b;
  logic          out_last;
  logic          busy;
  logic          done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] ta(input logic [3:0] ad);
    case (ad)
      4'd0, 4'd2, 4'd14, 4'd15: return 16'h1000;
      4'd1:                     return 16'h0000;
      4'd3:                     return 16'h2000;
      4'd9:                     return 16'h1234;
      default:                  return {12'hA00, ad};
    endcase
  endfunction

  function automatic logic [15:0] tbv(input logic [3:0] ad);
    case (ad)
      4'd1, 4'd2:                      return 16'h1000;
      4'd0, 4'd3, 4'd9, 4'd14, 4'd15: return 16'h0000;
      default:                         return {12'hB00, ad};
    endcase
  endfunction

  assign tbl_sigA = ta(tbl_addr);
  assign tbl_sigB = tbv(tbl_addr);

  wave_tbl_player #(.A(A), .D(D), .HOLD_W(HW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .loop     (loop),
    .addr_lo  (addr_lo),
    .addr_hi  (addr_hi),
    .hold     (hold),
    .tbl_addr (tbl_addr),
    .tbl_sigA (tbl_sigA),
    .tbl_sigB (tbl_sigB),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_a    (out_a),
    .out_b    (out_b),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  typedef struct packed {
    logic [3:0]  ad;
    logic [15:0] a;
    logic [15:0] b;
    logic        last;
  } smp_t;

  typedef struct {
    int lo;
    int hi;
    bit lp;
    int hd;
    int stop_k;
    int rdy;
    int stall;
    int exp_n;
    int exp_last;
  } vec_t;

  smp_t eq[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: the expected stream is the range walked entry by entry,
  // each entry emitted hd+1 times; a stop after k transfers allows k+1.
  task automatic build(input int lo, input int hi, input bit lp,
                       input int hd, input int stop_k);
    int nent;
    int lim;
    int i;
    logic [3:0] ad;
    eq.delete();
    nent = ((hi - lo + 16) % 16) + 1;
    lim  = (stop_k >= 0) ? stop_k + 1 : nent * (hd + 1);
    i = 0;
    while (eq.size() < lim) begin
      ad = 4'((lo + (i % nent)) % 16);
      for (int r = 0; r <= hd && eq.size() < lim; r++)
        eq.push_back('{ad, ta(ad), tbv(ad),
          (stop_k < 0 && !lp && i == nent - 1 && r == hd)});
      i++;
    end
  endtask

  task automatic run_seq(input int lo, input int hi, input bit lp,
                         input int hd, input int stop_k, input int rdy,
                         input int stall, output int got,
                         output int lasts);
    int cyc;
    int dones;
    int first_v;
    int stall_left;
    bit pend;
    bit notbusy;
    bit stop_sent;
    logic [32:0] prev;
    build(lo, hi, lp, hd, stop_k);
    @(negedge clk);
    addr_lo = lo[3:0];
    addr_hi = hi[3:0];
    loop = lp;
    hold = hd[7:0];
    start = 1'b1;
    stop = 1'b0;
    out_ready = 1'b0;
    got = 0; lasts = 0; cyc = 0; dones = 0; first_v = -1;
    stall_left = stall; pend = 0; notbusy = 0; stop_sent = 0;
    prev = '0;
    while (got < eq.size() && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (pend)
        chk("hold_stable", {out_valid, out_a, out_b, out_last},
            {1'b1, prev});
      if (done) dones++;
      if (!busy) notbusy = 1;
      if (out_valid && first_v < 0) first_v = cyc;
      // Extra starts and config churn while busy must be ignored.
      start   = ($urandom_range(7) == 0);
      addr_lo = 4'($urandom);
      addr_hi = 4'($urandom);
      loop    = 1'($urandom);
      hold    = 8'($urandom);
      stop    = 1'b0;
      if (stop_k >= 0 && got == stop_k && !stop_sent) begin
        stop = 1'b1;
        stop_sent = 1;
        out_ready = 1'b0;
      end else if (out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
        chk("stall_smp", {out_a, out_b, out_last},
            {eq[got].a, eq[got].b, eq[got].last});
      end else begin
        out_ready = ($urandom_range(99) < rdy);
      end
      #1;
      pend = out_valid && !out_ready;
      prev = {out_a, out_b, out_last};
      if (out_valid && out_ready) begin
        if (out_last) lasts++;
        chk($sformatf("xfer%0d", got),
            {tbl_addr, out_a, out_b, out_last}, eq[got]);
        got++;
      end
    end
    chk("count", got, eq.size());
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    out_ready = 1'($urandom);
    chk("done_pulse", {done, busy, out_valid}, 3'b100);
    chk("early_done", dones, 0);
    chk("busy_thru", notbusy, 0);
    chk("latency", first_v, 2);
    repeat (3) begin
      @(negedge clk);
      chk("idle_after", {done, busy, out_valid}, 3'b000);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[8];
    int got;
    int lasts;
    int lo;
    int hi;
    int hd;
    int sk;
    bit lp;

    vt[0] = '{0, 2, 0, 0, -1, 100, 0, 3, 1};
    vt[1] = '{9, 9, 0, 2, -1, 100, 0, 3, 1};
    vt[2] = '{3, 5, 0, 0, -1, 100, 5, 3, 1};
    vt[3] = '{14, 1, 0, 0, -1, 100, 0, 4, 1};
    vt[4] = '{3, 5, 1, 0, 7, 100, 0, 8, 0};
    vt[5] = '{0, 15, 0, 1, -1, 70, 0, 32, 1};
    vt[6] = '{5, 4, 0, 0, -1, 50, 0, 16, 1};
    vt[7] = '{6, 8, 1, 2, 10, 60, 0, 11, 0};

    rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
    addr_lo = '0; addr_hi = '0; hold = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset", {out_valid, out_a, out_b, out_last, busy, done,
                  tbl_addr}, '0);
    rst = 1'b0;

    for (int k = 0; k < 8; k++) begin
      run_seq(vt[k].lo, vt[k].hi, vt[k].lp, vt[k].hd, vt[k].stop_k,
              vt[k].rdy, vt[k].stall, got, lasts);
      chk($sformatf("vec%0d_n", k), got, vt[k].exp_n);
      chk($sformatf("vec%0d_last", k), lasts, vt[k].exp_last);
    end

    // Reset in the middle of a stalled transfer, with start also high.
    @(negedge clk);
    addr_lo = 4'd0; addr_hi = 4'd2; loop = 1'b0; hold = '0;
    start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int w = 0; w < 10 && !out_valid; w++) @(negedge clk);
    chk("pre_rst_valid", out_valid, 1'b1);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("rst_mid", {out_valid, busy, tbl_addr, done, out_last}, '0);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst_stay_idle", {busy, out_valid}, 2'b00);

    for (int k = 0; k < 20; k++) begin
      lo = $urandom_range(15);
      hi = $urandom_range(15);
      hd = $urandom_range(3);
      lp = 1'($urandom);
      sk = lp ? int'($urandom_range(20, 1)) : -1;
      run_seq(lo, hi, lp, hd, sk, $urandom_range(100, 40), 0,
              got, lasts);
      chk($sformatf("rnd%0d_last", k), lasts, (lp ? 0 : 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
